// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: branch op encodings,
// BHT counter geometry and the redirect sequencing states.
package branch_predict_unit_pkg;

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] BHT_RST_VAL = 2'b01;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLEZ = 3'd2,
    OP_BGTZ = 3'd3,
    OP_BLTZ = 3'd4,
    OP_BGEZ = 3'd5
  } br_op_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } redir_state_e;

  function automatic logic op_is_defined(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Branch history table access bundle: one combinational read, one update.
interface branch_predict_unit_if
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned NB_IDX = 4
);
  logic [NB_IDX-1:0] rd_idx;
  logic [CNT_W-1:0]  rd_cnt;
  logic              wr_en;
  logic [NB_IDX-1:0] wr_idx;
  logic              wr_taken;

  modport master (output rd_idx, wr_en, wr_idx, wr_taken, input rd_cnt);
  modport slave  (input rd_idx, wr_en, wr_idx, wr_taken, output rd_cnt);
endinterface

// File: rtl/branch_predict_unit_bht_table.sv
// Table of 2-bit saturating counters; the read port sees the pre-update
// value when the same entry is written in the same cycle.
module bht_table
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 16
)(
  input  logic                 clock,
  input  logic                 reset_n,
  branch_predict_unit_if.slave bus
);

  logic [CNT_W-1:0] r_cnt [BHT_DEPTH];
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_next;

  assign bus.rd_cnt = r_cnt[bus.rd_idx];
  assign w_cur      = r_cnt[bus.wr_idx];

  always_comb begin
    w_next = w_cur;
    if (bus.wr_taken) begin
      if (w_cur != '1) w_next = w_cur + 1'b1;
    end else begin
      if (w_cur != '0) w_next = w_cur - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= BHT_RST_VAL;
    end else if (bus.wr_en) begin
      r_cnt[bus.wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage branch resolution with BHT prediction, one-cycle redirect pulse
// and saturating statistics counters; i_enable=0 freezes everything.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_ADDR   = 7,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned NB_CNT    = 16
)(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NB_ADDR-1:0] i_fetch_pc,
  output logic               o_pred_taken,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [2:0]         i_op,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic               i_pred,
  input  logic               i_hazard,
  output logic               o_stall,
  output logic               o_redirect,
  output logic [NB_ADDR-1:0] o_redirect_addr,
  output logic [NB_CNT-1:0]  o_branch_cnt,
  output logic [NB_CNT-1:0]  o_mispred_cnt
);

  localparam int unsigned NB_IDX = $clog2(BHT_DEPTH);

  redir_state_e       r_state;
  redir_state_e       w_state_next;
  logic [NB_ADDR-1:0] r_redirect_addr;
  logic [NB_CNT-1:0]  r_branch_cnt;
  logic [NB_CNT-1:0]  r_mispred_cnt;

  logic               w_resolve;
  logic               w_op_ok;
  logic               w_taken;
  logic               w_mispred;
  logic               w_update;
  logic               w_a_neg;
  logic               w_a_zero;
  logic               w_redirect;
  logic [NB_ADDR-1:0] w_target;
  logic [NB_ADDR-1:0] w_pc_m1;
  logic               w_unused;

  branch_predict_unit_if #(.NB_IDX(NB_IDX)) w_bht ();

  bht_table #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (w_bht.slave)
  );

  assign o_stall   = i_valid & i_hazard;
  assign w_resolve = i_enable & i_valid & ~i_hazard;
  assign w_a_neg   = i_data_a[NB_DATA-1];
  assign w_a_zero  = (i_data_a == '0);
  assign w_target  = i_pc + i_imm[NB_ADDR-1:0];
  assign w_pc_m1   = i_pc - NB_ADDR'(1);

  always_comb begin
    w_taken = 1'b0;
    w_op_ok = op_is_defined(i_op);
    case (br_op_e'(i_op))
      OP_BEQ:  w_taken = (i_data_a == i_data_b);
      OP_BNE:  w_taken = (i_data_a != i_data_b);
      OP_BLEZ: w_taken = w_a_neg | w_a_zero;
      OP_BGTZ: w_taken = ~w_a_neg & ~w_a_zero;
      OP_BLTZ: w_taken = w_a_neg;
      OP_BGEZ: w_taken = ~w_a_neg;
      default: w_taken = 1'b0;
    endcase
  end

  // Reserved ops may still redirect (to fall-through) but never train or count.
  assign w_mispred = w_resolve & (w_taken != i_pred);
  assign w_update  = w_resolve & w_op_ok;

  assign w_bht.rd_idx   = i_fetch_pc[NB_IDX-1:0];
  assign w_bht.wr_en    = w_update;
  assign w_bht.wr_idx   = w_pc_m1[NB_IDX-1:0];
  assign w_bht.wr_taken = w_taken;
  assign o_pred_taken   = w_bht.rd_cnt[1];

  // A disabled cycle holds the pending state, so the pulse slips to the next enabled cycle.
  always_comb begin
    w_state_next = r_state;
    w_redirect   = 1'b0;
    if (i_enable) begin
      case (r_state)
        RD_PEND: w_redirect = 1'b1;
        default: w_redirect = 1'b0;
      endcase
      w_state_next = w_mispred ? RD_PEND : RD_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= RD_IDLE;
      r_redirect_addr <= '0;
      r_branch_cnt    <= '0;
      r_mispred_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_mispred) r_redirect_addr <= w_taken ? w_target : i_pc;
      if (w_update && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_update && w_mispred && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign o_redirect      = w_redirect;
  assign o_redirect_addr = r_redirect_addr;
  assign o_branch_cnt    = r_branch_cnt;
  assign o_mispred_cnt   = r_mispred_cnt;

  assign w_unused = ^{i_imm[NB_DATA-1:NB_ADDR], w_pc_m1[NB_ADDR-1:NB_IDX], w_bht.rd_cnt[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [6:0]  i_fetch_pc;
  logic        o_pred_taken;
  logic        i_enable;
  logic        i_valid;
  logic [2:0]  i_op;
  logic [6:0]  i_pc;
  logic [31:0] i_imm;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        i_pred;
  logic        i_hazard;
  logic        o_stall;
  logic        o_redirect;
  logic [6:0]  o_redirect_addr;
  logic [15:0] o_branch_cnt;
  logic [15:0] o_mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_predict_unit #(
    .NB_DATA(32), .NB_ADDR(7), .BHT_DEPTH(16), .NB_CNT(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_fetch_pc(i_fetch_pc), .o_pred_taken(o_pred_taken),
    .i_enable(i_enable), .i_valid(i_valid), .i_op(i_op),
    .i_pc(i_pc), .i_imm(i_imm), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .i_pred(i_pred), .i_hazard(i_hazard), .o_stall(o_stall),
    .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 clock = ~clock;

  task automatic drive_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] pc, input logic [31:0] imm, input logic pred);
    i_valid = 1'b1; i_op = op; i_data_a = a; i_data_b = b;
    i_pc = pc; i_imm = imm; i_pred = pred; i_hazard = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_hazard = 1'b0;
    i_op = 3'd0; i_pc = '0; i_imm = '0; i_data_a = '0; i_data_b = '0;
    i_pred = 1'b0; i_fetch_pc = '0;
    repeat (2) @(negedge clock);
    total++; if (o_branch_cnt !== 16'd0 || o_mispred_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", o_branch_cnt, o_mispred_cnt); end
    total++; if (o_redirect !== 1'b0 || o_redirect_addr !== 7'd0) begin
      bad++; $display("FAIL reset_redir got %b/%0d want 0/0", o_redirect, o_redirect_addr); end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_fetch_pc = 7'(i); #0.5;
      total++; if (o_pred_taken !== 1'b0) begin
        bad++; $display("FAIL reset_pred[%0d] got %b want 0", i, o_pred_taken); end
    end
    @(negedge clock);
  endtask

  task automatic test_beq_taken;
    drive_br(3'd0, 32'd5, 32'd5, 7'd10, 32'd4, 1'b0);
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_redirect !== 1'b1 || o_redirect_addr !== 7'd14) begin
      bad++; $display("FAIL beq_redir got %b/%0d want 1/14", o_redirect, o_redirect_addr); end
    total++; if (o_branch_cnt !== 16'd1 || o_mispred_cnt !== 16'd1) begin
      bad++; $display("FAIL beq_cnt got %0d/%0d want 1/1", o_branch_cnt, o_mispred_cnt); end
    i_fetch_pc = 7'd9; #1;
    total++; if (o_pred_taken !== 1'b1) begin
      bad++; $display("FAIL beq_bht9 got %b want 1", o_pred_taken); end
    @(negedge clock);
    total++; if (o_redirect !== 1'b0 || o_redirect_addr !== 7'd14) begin
      bad++; $display("FAIL beq_pulse_end got %b/%0d want 0/14", o_redirect, o_redirect_addr); end
  endtask

  task automatic test_bgtz_neg;
    drive_br(3'd3, 32'hFFFF_FFFF, 32'd99, 7'd20, 32'd8, 1'b0);
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_redirect !== 1'b0) begin
      bad++; $display("FAIL bgtz_redir got %b want 0", o_redirect); end
    total++; if (o_branch_cnt !== 16'd2 || o_mispred_cnt !== 16'd1) begin
      bad++; $display("FAIL bgtz_cnt got %0d/%0d want 2/1", o_branch_cnt, o_mispred_cnt); end
  endtask

  task automatic test_stall;
    drive_br(3'd0, 32'd1, 32'd2, 7'd40, 32'd3, 1'b0);
    i_hazard = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (o_stall !== 1'b1 || o_branch_cnt !== 16'd2) begin
        bad++; $display("FAIL stall_hold[%0d] got %b/%0d want 1/2", c, o_stall, o_branch_cnt); end
      @(negedge clock);
    end
    i_hazard = 1'b0; #1;
    total++; if (o_stall !== 1'b0) begin
      bad++; $display("FAIL stall_release got %b want 0", o_stall); end
    @(negedge clock); i_valid = 1'b0;
    @(negedge clock);
    total++; if (o_branch_cnt !== 16'd3 || o_mispred_cnt !== 16'd1) begin
      bad++; $display("FAIL stall_once got %0d/%0d want 3/1", o_branch_cnt, o_mispred_cnt); end
  endtask

  task automatic test_wrap;
    drive_br(3'd0, 32'd7, 32'd7, 7'd120, 32'd10, 1'b0);
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_redirect !== 1'b1 || o_redirect_addr !== 7'd2) begin
      bad++; $display("FAIL wrap_redir got %b/%0d want 1/2", o_redirect, o_redirect_addr); end
    total++; if (o_branch_cnt !== 16'd4 || o_mispred_cnt !== 16'd2) begin
      bad++; $display("FAIL wrap_cnt got %0d/%0d want 4/2", o_branch_cnt, o_mispred_cnt); end
    @(negedge clock);
  endtask

  task automatic test_enable_freeze;
    drive_br(3'd1, 32'd1, 32'd2, 7'd50, 32'hFFFF_FFFD, 1'b0);
    @(negedge clock);
    i_enable = 1'b0;
    drive_br(3'd0, 32'd3, 32'd3, 7'd80, 32'd1, 1'b0);
    #1;
    total++; if (o_redirect !== 1'b0) begin
      bad++; $display("FAIL freeze_redir got %b want 0", o_redirect); end
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_branch_cnt !== 16'd5 || o_mispred_cnt !== 16'd3 || o_redirect_addr !== 7'd47) begin
      bad++; $display("FAIL freeze_state got %0d/%0d/%0d want 5/3/47", o_branch_cnt, o_mispred_cnt, o_redirect_addr); end
    i_enable = 1'b1; #1;
    total++; if (o_redirect !== 1'b1 || o_redirect_addr !== 7'd47) begin
      bad++; $display("FAIL freeze_deliver got %b/%0d want 1/47", o_redirect, o_redirect_addr); end
    @(negedge clock);
    total++; if (o_redirect !== 1'b0) begin
      bad++; $display("FAIL freeze_once got %b want 0", o_redirect); end
  endtask

  task automatic test_reserved;
    drive_br(3'd6, 32'd0, 32'd0, 7'd60, 32'd5, 1'b1);
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_redirect !== 1'b1 || o_redirect_addr !== 7'd60) begin
      bad++; $display("FAIL rsvd_redir got %b/%0d want 1/60", o_redirect, o_redirect_addr); end
    total++; if (o_branch_cnt !== 16'd5 || o_mispred_cnt !== 16'd3) begin
      bad++; $display("FAIL rsvd_cnt got %0d/%0d want 5/3", o_branch_cnt, o_mispred_cnt); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    drive_br(3'd2, 32'd0, 32'd9, 7'd70, 32'd6, 1'b1);
    @(negedge clock);
    drive_br(3'd5, 32'hFFFF_FFFB, 32'd0, 7'd71, 32'd6, 1'b1);
    #1;
    total++; if (o_redirect !== 1'b0 || o_branch_cnt !== 16'd6 || o_mispred_cnt !== 16'd3) begin
      bad++; $display("FAIL b2b_blez got %b/%0d/%0d want 0/6/3", o_redirect, o_branch_cnt, o_mispred_cnt); end
    @(negedge clock); i_valid = 1'b0;
    total++; if (o_redirect !== 1'b1 || o_redirect_addr !== 7'd71) begin
      bad++; $display("FAIL b2b_bgez got %b/%0d want 1/71", o_redirect, o_redirect_addr); end
    total++; if (o_branch_cnt !== 16'd7 || o_mispred_cnt !== 16'd4) begin
      bad++; $display("FAIL b2b_cnt got %0d/%0d want 7/4", o_branch_cnt, o_mispred_cnt); end
    @(negedge clock);
  endtask

  task automatic test_saturation;
    // Entry 9 is at 10; three taken saturate it at 11, then two not-taken reach 01.
    i_fetch_pc = 7'd9;
    for (int k = 0; k < 3; k++) begin
      drive_br(3'd0, 32'd4, 32'd4, 7'd10, 32'd4, 1'b1);
      @(negedge clock);
    end
    drive_br(3'd0, 32'd4, 32'd5, 7'd10, 32'd4, 1'b1);
    @(negedge clock); i_valid = 1'b0; #1;
    total++; if (o_pred_taken !== 1'b1 || o_redirect !== 1'b1 || o_redirect_addr !== 7'd10) begin
      bad++; $display("FAIL sat_first_nt got %b/%b/%0d want 1/1/10", o_pred_taken, o_redirect, o_redirect_addr); end
    drive_br(3'd0, 32'd4, 32'd5, 7'd10, 32'd4, 1'b1);
    @(negedge clock); i_valid = 1'b0; #1;
    total++; if (o_pred_taken !== 1'b0) begin
      bad++; $display("FAIL sat_second_nt got %b want 0", o_pred_taken); end
    total++; if (o_branch_cnt !== 16'd12 || o_mispred_cnt !== 16'd6) begin
      bad++; $display("FAIL sat_cnt got %0d/%0d want 12/6", o_branch_cnt, o_mispred_cnt); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    i_fetch_pc = 7'd1; #1;
    total++; if (o_pred_taken !== 1'b1) begin
      bad++; $display("FAIL rmid_pre_bht1 got %b want 1", o_pred_taken); end
    @(negedge clock);
    drive_br(3'd0, 32'd5, 32'd5, 7'd10, 32'd4, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0; i_valid = 1'b0; #1;
    total++; if (o_redirect !== 1'b0 || o_redirect_addr !== 7'd0 || o_branch_cnt !== 16'd0 || o_mispred_cnt !== 16'd0) begin
      bad++; $display("FAIL rmid_async got %b/%0d/%0d/%0d want 0/0/0/0", o_redirect, o_redirect_addr, o_branch_cnt, o_mispred_cnt); end
    @(negedge clock); reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++; if (o_redirect !== 1'b0) begin
        bad++; $display("FAIL rmid_no_pulse[%0d] got %b want 0", c, o_redirect); end
    end
    i_fetch_pc = 7'd1; #1;
    total++; if (o_pred_taken !== 1'b0) begin
      bad++; $display("FAIL rmid_bht1 got %b want 0", o_pred_taken); end
    i_fetch_pc = 7'd9; #1;
    total++; if (o_pred_taken !== 1'b0) begin
      bad++; $display("FAIL rmid_bht9 got %b want 0", o_pred_taken); end
  endtask

  initial begin
    test_reset;
    test_beq_taken;
    test_bgtz_neg;
    test_stall;
    test_wrap;
    test_enable_freeze;
    test_reserved;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter NB_DATA, default 32, operand and immediate width.
REQ-002 Parameter NB_ADDR, default 7, instruction-memory word-address width.
REQ-003 Parameter BHT_DEPTH, default 16, branch history table entries; power of two, at least 2.
REQ-004 Parameter NB_CNT, default 16, width of statistics counters.
REQ-005 Port clock, input, 1, single clock; all state on rising edge.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port i_fetch_pc, input, NB_ADDR, PC being fetched (prediction lookup).
REQ-008 Port o_pred_taken, output, 1, combinational prediction for i_fetch_pc.
REQ-009 Port i_enable, input, 1, pipeline advance; 0 freezes all state (debug step mode).
REQ-010 Port i_valid, input, 1, conditional branch present in ID.
REQ-011 Port i_op, input, 3, compare mode: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6-7 reserved.
REQ-012 Port i_pc, input, NB_ADDR, PC+1 of the branch in ID.
REQ-013 Port i_imm, input, NB_DATA, sign-extended word offset.
REQ-014 Port i_data_a / i_data_b, input, NB_DATA each, forwarded rs/rt values.
REQ-015 Port i_pred, input, 1, prediction carried down with the branch from IF.
REQ-016 Port i_hazard, input, 1, an ID operand is not yet available.
REQ-017 Port o_stall, output, 1, hold IF/ID.
REQ-018 Port o_redirect, output, 1, one-cycle flush-and-redirect pulse.
REQ-019 Port o_redirect_addr, output, NB_ADDR, corrected fetch address.
REQ-020 Port o_branch_cnt / o_mispred_cnt, output, NB_CNT each, statistics for the debug unit.

Function
REQ-021 o_stall SHALL equal i_valid AND i_hazard, combinationally.
REQ-022 A branch resolves on a rising edge with i_enable=1, i_valid=1, i_hazard=0.
REQ-023 Comparisons: BEQ a==b; BNE a!=b; BLEZ/BGTZ/BLTZ/BGEZ compare signed a against 0 and ignore b.
REQ-024 A reserved op SHALL resolve as not-taken and SHALL NOT update the BHT or the counters.
REQ-025 Target = (i_pc + i_imm) truncated to NB_ADDR bits; wrap-around is modulo 2^NB_ADDR.
REQ-026 Fall-through = i_pc.
REQ-027 Mispredict when actual taken differs from i_pred.
REQ-028 The cycle after a mispredicting resolution, o_redirect=1 for exactly one cycle, with o_redirect_addr = target if taken, else fall-through.
REQ-029 When there is no redirect, o_redirect=0 and o_redirect_addr holds its last value.
REQ-030 BHT: BHT_DEPTH 2-bit saturating counters, indexed by PC[log2(BHT_DEPTH)-1:0].
REQ-031 o_pred_taken = counter[index(i_fetch_pc)][1].
REQ-032 On resolution, update the entry indexed by i_pc-1: increment on taken (saturate at 3), decrement on not-taken (saturate at 0).
REQ-033 Same-cycle fetch read and update of one entry SHALL return the pre-update value.
REQ-034 o_branch_cnt increments on each resolution; o_mispred_cnt increments on each mispredict; both saturate at all-ones.
REQ-035 i_enable=0 SHALL freeze BHT, counters and o_redirect_addr, and force o_redirect to 0 that cycle.
REQ-036 A pending redirect whose pulse cycle has i_enable=0 is delivered on the next enabled cycle.

Reset
REQ-037 reset_n low SHALL asynchronously set every BHT entry to 01, o_redirect=0, o_redirect_addr=0, and both counters to 0.
REQ-038 Reset mid-operation SHALL discard any pending redirect; no pulse follows reset release.

Structure
REQ-039 A shared package SHALL hold the branch op encodings, the BHT counter reset value (01), and the 2-bit counter width.
REQ-040 The BHT SHALL be the sub-module bht_table: one combinational read port, one synchronous write port, asynchronous reset.

Verification
REQ-041 Check: after reset, every fetch PC gives o_pred_taken=0 and both counters read 0.
REQ-042 Check: BEQ, a=b=5, i_pc=10, imm=4, i_pred=0 -> next cycle o_redirect=1, addr=14; entry 9 goes to 10.
REQ-043 Check: BGTZ, a=-1, i_pred=0 -> no redirect; o_branch_cnt +1, o_mispred_cnt unchanged.
REQ-044 Check: i_hazard=1 for 3 cycles, then 0 -> o_stall high 3 cycles; exactly one resolution.
REQ-045 Check: i_pc=120, imm=10, NB_ADDR=7, taken, mispredicted -> o_redirect_addr=2 (wrap).
REQ-046 Check: reset_n asserted in the cycle after a mispredict -> no o_redirect pulse after release; BHT back to 01.
